// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered occupancy/threshold flags and one-cycle error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is 1-cycle registered reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Handshake: a write is taken when wr_en=1 and (full=0 or a read is taken in the
  // same cycle); a read is taken when rd_en=1 and empty=0. Rejected requests raise
  // overflow/underflow for one cycle and leave pointers and storage untouched.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_accept;
  logic          wr_accept;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;

  assign rd_addr = rd_ptr_q[AW-1:0];
  assign wr_addr = wr_ptr_q[AW-1:0];

  always_comb begin
    rd_accept   = rd_en && !empty_q;
    wr_accept   = wr_en && (!full_q || rd_accept);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d  = wr_en && !wr_accept;
    underflow_d = rd_en && empty_q;
    if (rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // Equal addresses with differing wrap bits means full; identical pointers means
    // empty. This agrees with count_d == DEPTH / count_d == 0 by construction.
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    full_q      <= full_d;
    empty_q     <= empty_d;
    af_q        <= af_d;
    ae_q        <= ae_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // Storage is deliberately not reset; pointers guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) mem_q[wr_addr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty_q ? '0 : mem_q[rd_addr];
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_accept) data_out_d = mem_q[rd_addr];
    if (rst)       data_out_d = '0;
  end

  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (8x16): a queue-based model predicts every
// cycle's outputs; a monitor compares them after each rising edge.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  sync_fifo_param #(
    .DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic [7:0] model_dout = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the FIFO must show after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
    exp_t e;
    bit   was_full, was_empty, rd_acc, wr_acc;
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; rst = rs;
    e = '0;
    if (rs) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      was_full  = (model_q.size() == 16);
      was_empty = (model_q.size() == 0);
      rd_acc    = r && !was_empty;
      wr_acc    = w && (!was_full || rd_acc);
      e.ov      = w && !wr_acc;
      e.un      = r && was_empty;
      if (rd_acc) model_dout = model_q.pop_front();
      if (wr_acc) model_q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    e.dout = (model_q.size() == 0) ? 8'h00 : model_q[0];
`else
    e.dout = model_dout;
`endif
    e.cnt   = 5'(model_q.size());
    e.full  = (model_q.size() == 16);
    e.empty = (model_q.size() == 0);
    e.af    = (model_q.size() >= 14);
    e.ae    = (model_q.size() <= 2);
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0); endtask
  task automatic rd();                    step(1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic idle();                  step(1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic reset_cycle();           step(1'b0, 8'h00, 1'b0, 1'b1); endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_out",     int'(data_out),     int'(e.dout));
        check("count",        int'(count),        int'(e.cnt));
        check("full",         int'(full),         int'(e.full));
        check("empty",        int'(empty),        int'(e.empty));
        check("almost_full",  int'(almost_full),  int'(e.af));
        check("almost_empty", int'(almost_empty), int'(e.ae));
        check("overflow",     int'(overflow),     int'(e.ov));
        check("underflow",    int'(underflow),    int'(e.un));
      end
    end
  end

  initial begin : stimulus
    int budget;
    reset_cycle();
    reset_cycle();
    idle();

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 1; i <= 16; i++) wr(8'(i));
    for (int i = 0; i < 16; i++) rd();
    idle();

    // Full: rejected write, then a write paired with a read.
    for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)));
    wr(8'h3C);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) rd();

    // Empty: simultaneous read+write gives underflow and stores the word.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    rd();
    idle();

    // Threshold crossings around both levels.
    for (int i = 0; i < 3; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 3; i++) rd();
    for (int i = 0; i < 14; i++) wr(8'(8'h60 + i));
    rd();
    wr(8'h7E);
    reset_cycle();

    // Wrap-around with interleaved traffic around mid occupancy.
    for (int i = 0; i < 6; i++) wr(8'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      wr(8'($urandom_range(0, 255)));
      rd();
    end
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // Mid-operation reset with a write request in the reset cycle.
    reset_cycle();
    for (int i = 0; i < 9; i++) wr(8'(8'h90 + i));
    step(1'b1, 8'h77, 1'b0, 1'b1);
    rd();
    wr(8'h01);
    idle();
    rd();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end

    idle();
    idle();
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits, legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 16: number of storage words, a power of two, at least 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port rd_en, input, 1 bit: read request.
REQ-010 SHALL have port data_out, output, DATA_WIDTH bits: read data.
REQ-011 SHALL have ports full and empty, outputs, 1 bit each: registered occupancy flags.
REQ-012 SHALL have ports almost_full and almost_empty, outputs, 1 bit each: registered threshold flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: current number of stored words, 0..DEPTH.
REQ-014 SHALL have ports overflow and underflow, outputs, 1 bit each: one-cycle error pulses.

Function
REQ-015 SHALL accept a write when wr_en=1 and (full=0, or full=1 and a read is accepted in the same cycle); accepted writes store data_in at wr_ptr, then advance wr_ptr.
REQ-016 SHALL accept a read when rd_en=1 and empty=0; a write in the same cycle never makes a read of an empty FIFO legal.
REQ-017 SHALL wrap wr_ptr and rd_ptr modulo DEPTH; an extra MSB wrap bit distinguishes full from empty.
REQ-018 SHALL update count next cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-019 SHALL register full, empty, almost_full and almost_empty from the next-state count, so they are valid in the same cycle count changes.
REQ-020 SHALL pulse overflow high for exactly one cycle when wr_en=1 and the write is rejected; FIFO contents and pointers stay unchanged.
REQ-021 SHALL pulse underflow high for exactly one cycle when rd_en=1 and empty=1; pointers stay unchanged.
REQ-022 SHALL, in standard mode, register mem[rd_ptr] into data_out on the edge that accepts a read (1-cycle read latency), and hold data_out at all other times.

Reset
REQ-023 SHALL, when rst=1 at a rising clk edge, clear wr_ptr, rd_ptr and count to 0, set empty=1 and almost_empty=1, and clear full, almost_full, overflow, underflow and data_out.
REQ-024 SHALL give rst priority over wr_en and rd_en; a request in the reset cycle is discarded with no error pulse.
REQ-025 SHALL NOT reset storage memory contents; no stale word is ever readable after reset.

Configuration
REQ-026 SHALL compile first-word fall-through mode when macro SYNC_FIFO_FWFT_EN is defined: data_out continuously shows mem[rd_ptr] whenever empty=0, a read pops that word, and read latency is 0.
REQ-027 SHALL, with SYNC_FIFO_FWFT_EN defined, drive data_out to 0 whenever empty=1.
REQ-028 SHALL, without SYNC_FIFO_FWFT_EN, behave as in REQ-022; flag, count and error behaviour are identical in both modes.

Verification (DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-029 SHALL cover: write 0x01..0x10, then read 16 words -> full=1 after the 16th write, data_out sequence 0x01..0x10 in order, empty=1 after the last read.
REQ-030 SHALL cover: FIFO full, wr_en=1 with rd_en=0 -> overflow=1 for one cycle, count stays 16; then wr_en=1 and rd_en=1 together -> write accepted, count stays 16, no overflow.
REQ-031 SHALL cover: FIFO empty, rd_en=1 and wr_en=1 with data_in=0xA5 -> underflow=1 for one cycle, count=1, next read returns 0xA5.
REQ-032 SHALL cover threshold edges: count 1->2 gives almost_empty=1, 2->3 gives 0; count 13->14 gives almost_full=1, 14->13 gives 0.
REQ-033 SHALL cover wrap-around: 40 interleaved write/read pairs with random data and count staying between 3 and 12 -> data order preserved, with no overflow or underflow.
REQ-034 SHALL cover mid-operation reset: count=9, rst=1 for one cycle with wr_en=1 -> count=0, empty=1, data_out=0, no overflow pulse; repeat REQ-029 with SYNC_FIFO_FWFT_EN defined -> data_out=0x01 in the cycle after the first write, before any rd_en.
